// File: rtl/frame_pingpong_buffer_pkg.sv
// Shared constants and types for the ping-pong frame buffer: default widths,
// writer-side state encoding and the read-data source select.
package frame_pingpong_buffer_pkg;

  localparam int FPB_DATA_W = 12;
  localparam int FPB_ADDR_W = 10;

  typedef enum logic {
    FPB_FILLING = 1'b0,
    FPB_READY   = 1'b1
  } fpb_state_e;

  typedef enum logic [1:0] {
    FPB_SRC_ZERO  = 2'd0,
    FPB_SRC_FILL  = 2'd1,
    FPB_SRC_BANK0 = 2'd2,
    FPB_SRC_BANK1 = 2'd3
  } fpb_rd_src_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_pingpong_buffer_dual_port_bank.sv
// One frame bank: single write port plus a single registered read port whose
// output holds its last value while re is low.
module dual_port_bank #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_pingpong_buffer.sv
// Two-bank frame buffer between a frame writer and a frame former: the writer
// fills ~bank_sel while the former reads bank_sel; swap_req flips the banks.
module frame_pingpong_buffer
  import frame_pingpong_buffer_pkg::*;
#(
  parameter int                DATA_W        = FPB_DATA_W,
  parameter int                ADDR_W        = FPB_ADDR_W,
  parameter int                FRAME_LEN     = 1024,
  parameter int                UNDERRUN_MODE = 0,
  parameter logic [DATA_W-1:0] FILL_WORD     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              swap_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              bank_sel,
  output logic              frame_ready,
  output logic [7:0]        underrun_cnt,
  output logic [7:0]        overrun_cnt,
  output fpb_state_e        dbg_state
);

  localparam logic [ADDR_W:0] LEN_LIM = (ADDR_W+1)'(FRAME_LEN);

  fpb_state_e  state_q, state_d;
  fpb_rd_src_e rd_src_q, rd_src_d;
  logic        bank_sel_q, bank_sel_d;
  logic        urun_q, urun_d;
  logic [7:0]  ucnt_q, ucnt_d;
  logic [7:0]  ocnt_q, ocnt_d;
  logic        rd_valid_q, rd_valid_d;

  logic        do_swap, underrun_evt, overrun_evt, wr_accept;
  logic        wr_addr_ok, rd_addr_ok;
  logic [DATA_W-1:0] rdata0, rdata1;

  assign wr_addr_ok = ({1'b0, wr_addr} < LEN_LIM);
  assign rd_addr_ok = ({1'b0, rd_addr} < LEN_LIM);

  // Writer-side FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FPB_FILLING;
    else        state_q <= state_d;
  end

  // A frame finished in the same cycle as swap_req is swapped out at once,
  // so the writer goes straight back to FILLING.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FPB_FILLING: if (wr_done && !swap_req) state_d = FPB_READY;
      FPB_READY:   if (swap_req) state_d = FPB_FILLING;
      default:     state_d = FPB_FILLING;
    endcase
  end

  always_comb begin
    frame_ready  = (state_q == FPB_READY);
    do_swap      = swap_req && ((state_q == FPB_READY) || wr_done);
    underrun_evt = swap_req && (state_q == FPB_FILLING) && !wr_done;
    overrun_evt  = (state_q == FPB_READY) && (wr_en || wr_done);
    wr_accept    = (state_q == FPB_FILLING) && wr_en && wr_addr_ok;
  end

  assign dbg_state = state_q;

  always_comb begin
    bank_sel_d = bank_sel_q ^ do_swap;
    urun_d     = urun_q;
    if (do_swap)           urun_d = 1'b0;
    else if (underrun_evt) urun_d = 1'b1;
    ucnt_d     = underrun_evt ? sat_inc8(ucnt_q) : ucnt_q;
    ocnt_d     = overrun_evt  ? sat_inc8(ocnt_q) : ocnt_q;
    rd_valid_d = rd_en;
    // Source is chosen with pre-edge bank_sel/underrun so a read in the swap
    // cycle still comes from the old bank.
    rd_src_d   = rd_src_q;
    if (rd_en) begin
      if (!rd_addr_ok || ((UNDERRUN_MODE != 0) && urun_q)) rd_src_d = FPB_SRC_FILL;
      else if (bank_sel_q)                                 rd_src_d = FPB_SRC_BANK1;
      else                                                 rd_src_d = FPB_SRC_BANK0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_sel_q <= 1'b0;
      urun_q     <= 1'b0;
      ucnt_q     <= 8'd0;
      ocnt_q     <= 8'd0;
      rd_valid_q <= 1'b0;
      rd_src_q   <= FPB_SRC_ZERO;
    end else begin
      bank_sel_q <= bank_sel_d;
      urun_q     <= urun_d;
      ucnt_q     <= ucnt_d;
      ocnt_q     <= ocnt_d;
      rd_valid_q <= rd_valid_d;
      rd_src_q   <= rd_src_d;
    end
  end

  dual_port_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (clk),
    .we    (wr_accept && bank_sel_q),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en && !bank_sel_q),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  dual_port_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (clk),
    .we    (wr_accept && !bank_sel_q),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en && bank_sel_q),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  // Bank read registers only update on their own reads, so the mux holds
  // rd_data steady between reads.
  always_comb begin
    case (rd_src_q)
      FPB_SRC_FILL:  rd_data = FILL_WORD;
      FPB_SRC_BANK0: rd_data = rdata0;
      FPB_SRC_BANK1: rd_data = rdata1;
      default:       rd_data = '0;
    endcase
  end

  assign rd_valid     = rd_valid_q;
  assign bank_sel     = bank_sel_q;
  assign underrun_cnt = ucnt_q;
  assign overrun_cnt  = ocnt_q;

endmodule

// File: tb/tb_frame_pingpong_buffer.sv
// Bench for frame_pingpong_buffer: two instances (repeat-mode and fill-mode)
// share one stimulus stream and one behavioural frame model.
module tb_frame_pingpong_buffer;
  import frame_pingpong_buffer_pkg::*;

  localparam int LEN_A  = 1024;
  localparam int LEN_B  = 1000;
  localparam int FILL_A = 12'h5A5;
  localparam int FILL_B = 12'hABC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en = 0, wr_done = 0, rd_en = 0, swap_req = 0;
  logic [9:0]  wr_addr = '0, rd_addr = '0;
  logic [11:0] wr_data = '0;

  logic [11:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, bank_sel_a, bank_sel_b;
  logic        frame_ready_a, frame_ready_b;
  logic [7:0]  ucnt_a, ucnt_b, ocnt_a, ocnt_b;
  fpb_state_e  dbg_a, dbg_b;

  frame_pingpong_buffer #(.DATA_W(12), .ADDR_W(10), .FRAME_LEN(LEN_A),
    .UNDERRUN_MODE(0), .FILL_WORD(12'h5A5)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .rd_en(rd_en), .rd_addr(rd_addr), .swap_req(swap_req),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .bank_sel(bank_sel_a),
    .frame_ready(frame_ready_a), .underrun_cnt(ucnt_a), .overrun_cnt(ocnt_a),
    .dbg_state(dbg_a));

  frame_pingpong_buffer #(.DATA_W(12), .ADDR_W(10), .FRAME_LEN(LEN_B),
    .UNDERRUN_MODE(1), .FILL_WORD(12'hABC)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .rd_en(rd_en), .rd_addr(rd_addr), .swap_req(swap_req),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .bank_sel(bank_sel_b),
    .frame_ready(frame_ready_b), .underrun_cnt(ucnt_b), .overrun_cnt(ocnt_b),
    .dbg_state(dbg_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame contents per bank; -1 marks a word whose value is not known.
  int mem [2][1024];
  bit m_sel, m_ready, m_urun;
  int m_ucnt, m_ocnt;
  bit e_valid;
  int e_a, e_b, rv;
  bit e_a_k, e_b_k;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sel = 0; m_ready = 0; m_urun = 0; m_ucnt = 0; m_ocnt = 0;
      e_valid = 0; e_a = 0; e_b = 0; e_a_k = 1; e_b_k = 1;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 1024; i++) mem[b][i] = -1;
    end else begin
      e_valid = rd_en;
      if (rd_en) begin
        rv = mem[m_sel][rd_addr];
        if (int'(rd_addr) >= LEN_A) begin e_a = FILL_A; e_a_k = 1; end
        else begin e_a = rv; e_a_k = (rv >= 0); end
        if (int'(rd_addr) >= LEN_B || m_urun) begin e_b = FILL_B; e_b_k = 1; end
        else begin e_b = rv; e_b_k = (rv >= 0); end
      end
      if (m_ready) begin
        if (wr_en || wr_done) m_ocnt = (m_ocnt < 255) ? m_ocnt + 1 : 255;
        if (swap_req) begin m_sel = !m_sel; m_ready = 0; m_urun = 0; end
      end else begin
        if (wr_en) mem[!m_sel][wr_addr] = int'(wr_data);
        if (wr_done && swap_req) begin m_sel = !m_sel; m_urun = 0; end
        else if (wr_done) m_ready = 1;
        else if (swap_req) begin
          m_ucnt = (m_ucnt < 255) ? m_ucnt + 1 : 255;
          m_urun = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    chk("bank_sel_a", bank_sel_a, m_sel);
    chk("bank_sel_b", bank_sel_b, m_sel);
    chk("frame_ready_a", frame_ready_a, m_ready);
    chk("frame_ready_b", frame_ready_b, m_ready);
    chk("dbg_state_a", int'(dbg_a), int'(m_ready ? FPB_READY : FPB_FILLING));
    chk("underrun_cnt_a", ucnt_a, m_ucnt);
    chk("underrun_cnt_b", ucnt_b, m_ucnt);
    chk("overrun_cnt_a", ocnt_a, m_ocnt);
    chk("overrun_cnt_b", ocnt_b, m_ocnt);
    chk("rd_valid_a", rd_valid_a, e_valid);
    chk("rd_valid_b", rd_valid_b, e_valid);
    if (e_a_k) chk("rd_data_a", rd_data_a, e_a);
    if (e_b_k) chk("rd_data_b", rd_data_b, e_b);
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; inputs are sampled by the next rising edge and
  // the task returns on the following falling edge.
  task automatic drive(input bit we, input int wa, input int wd, input bit done,
                       input bit swp, input bit re, input int ra);
    wr_en = we; wr_addr = wa[9:0]; wr_data = wd[11:0]; wr_done = done;
    swap_req = swp; rd_en = re; rd_addr = ra[9:0];
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_frame(input int mul, input int add);
    for (int a = 0; a < 1024; a++)
      drive(1, a, (a * mul + add) & 12'hFFF, 0, 0,
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1023));
    idle();
  endtask

  task automatic read_both(input int addr, input int exp_a, input int exp_b);
    drive(0, 0, 0, 0, 0, 1, addr);
    chk("lit_rd_valid", rd_valid_a, 1);
    chk("lit_rd_data_a", rd_data_a, exp_a);
    chk("lit_rd_data_b", rd_data_b, exp_b);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rd_data_a", rd_data_a, 0);
    chk("reset_bank_sel", bank_sel_a, 0);
    reset = 1'b1;
    idle();

    // First frame, value addr+1, then swap and read it.
    write_frame(1, 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("lit_ready_after_done", frame_ready_a, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("lit_bank_sel_swap", bank_sel_a, 1);
    chk("lit_ready_after_swap", frame_ready_a, 0);
    read_both(5, 6, 6);
    idle();

    // Three swaps with no new frame.
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 1, 0, 0); idle(); end
    chk("lit_underrun_3", ucnt_a, 3);
    chk("lit_bank_sel_kept", bank_sel_b, 1);
    read_both(7, 8, FILL_B);

    // Good swap clears the underrun; B range limit still gives fill.
    write_frame(3, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    read_both(7, 21, 21);
    read_both(1000, 12'hBB8, FILL_B);
    read_both(1023, 12'hBFD, FILL_B);
    idle();

    // Overrun: 10 writes and one wr_done while a frame waits.
    write_frame(5, 2);
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, i, 12'hFFF, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("lit_overrun_11", ocnt_a, 11);
    drive(0, 0, 0, 0, 1, 0, 0);
    read_both(4, 22, 22);
    read_both(0, 2, 2);

    // wr_done and swap_req together.
    write_frame(1, 9);
    drive(0, 0, 0, 1, 1, 0, 0);
    chk("lit_both_bank_sel", bank_sel_a, 0);
    chk("lit_both_ready", frame_ready_a, 0);
    chk("lit_both_underrun", ucnt_b, 3);
    read_both(3, 12, 12);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 4095),
            ($urandom_range(0, 40) == 0), ($urandom_range(0, 60) == 0),
            $urandom_range(0, 1), $urandom_range(0, 1023));
    idle();

    // Saturate both counters, then reset in the middle of a fill.
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) drive(0, 0, 0, 0, 1, 0, 0);
    chk("lit_underrun_sat", ucnt_a, 255);
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) drive(1, i, i, 0, 0, 0, 0);
    chk("lit_overrun_sat", ocnt_b, 255);
    chk("lit_underrun_still_sat", ucnt_b, 255);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 50; i++) drive(1, i, i, 0, 0, 1, i);
    #2 reset = 1'b0;
    #1;
    chk("lit_rst_bank_sel", bank_sel_a, 0);
    chk("lit_rst_ready", frame_ready_b, 0);
    chk("lit_rst_valid_a", rd_valid_a, 0);
    chk("lit_rst_valid_b", rd_valid_b, 0);
    chk("lit_rst_data_a", rd_data_a, 0);
    chk("lit_rst_data_b", rd_data_b, 0);
    chk("lit_rst_ucnt", ucnt_a, 0);
    chk("lit_rst_ocnt", ocnt_b, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    idle();

    // Partial frame is gone: a swap now is an underrun.
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("lit_post_rst_underrun", ucnt_a, 1);
    chk("lit_post_rst_ready", frame_ready_a, 0);
    write_frame(2, 5);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("lit_post_rst_done", frame_ready_b, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("lit_post_rst_swap", bank_sel_a, 1);
    read_both(10, 25, 25);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_pingpong_buffer.md
FRAME_PINGPONG_BUFFER -- requirements
Module: frame_pingpong_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 12: word width.
REQ-002 SHALL have parameter ADDR_W, default 10: bank address width.
REQ-003 SHALL have parameter FRAME_LEN, default 1024: words per frame, 1..2**ADDR_W.
REQ-004 SHALL have parameter UNDERRUN_MODE, default 0: 0 = repeat last frame, 1 = output FILL_WORD.
REQ-005 SHALL have parameter FILL_WORD, default 0: word returned on underrun (mode 1) or out-of-range read.
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port wr_en, input, 1: write strobe into the write bank.
REQ-009 SHALL have port wr_addr, input, ADDR_W: write address.
REQ-010 SHALL have port wr_data, input, DATA_W: write word.
REQ-011 SHALL have port wr_done, input, 1: single-cycle pulse, writer finished a frame.
REQ-012 SHALL have port rd_en, input, 1: read strobe from the frame former.
REQ-013 SHALL have port rd_addr, input, ADDR_W: read address.
REQ-014 SHALL have port swap_req, input, 1: single-cycle pulse, frame former starts a new frame.
REQ-015 SHALL have port rd_data, output, DATA_W: read word.
REQ-016 SHALL have port rd_valid, output, 1: rd_data valid.
REQ-017 SHALL have port bank_sel, output, 1: bank currently being read.
REQ-018 SHALL have port frame_ready, output, 1: completed frame waiting in the write bank.
REQ-019 SHALL have port underrun_cnt, output, 8: swaps without a ready frame, saturating.
REQ-020 SHALL have port overrun_cnt, output, 8: writes or wr_done dropped while frame_ready, saturating.

Function
REQ-021 SHALL hold two banks of 2**ADDR_W x DATA_W; the write bank is always ~bank_sel.
REQ-022 SHALL use states FILLING (frame_ready=0) and READY (frame_ready=1).
REQ-023 In FILLING, SHALL write wr_data at wr_addr on wr_en; wr_done moves to READY.
REQ-024 In READY, SHALL drop wr_en writes and extra wr_done pulses, incrementing overrun_cnt once per dropped cycle.
REQ-025 On swap_req in READY, SHALL toggle bank_sel, clear the underrun flag and return to FILLING, all on the next edge.
REQ-026 On swap_req in FILLING, SHALL keep bank_sel, increment underrun_cnt and set the internal underrun flag until the next successful swap.
REQ-027 When swap_req and wr_done are asserted in the same FILLING cycle, SHALL accept the frame and swap immediately, leaving no underrun and the state FILLING.
REQ-028 When the underrun flag is set and UNDERRUN_MODE=1, SHALL return FILL_WORD for every read; when UNDERRUN_MODE=0, SHALL repeat the stored frame.
REQ-029 SHALL present rd_data and rd_valid exactly 1 cycle after rd_en, with rd_valid=1 for one cycle; with no rd_en, rd_valid=0 and rd_data holds its value.
REQ-030 When rd_addr >= FRAME_LEN, SHALL return FILL_WORD; when wr_addr >= FRAME_LEN, SHALL ignore the write.
REQ-031 A read issued in the swap cycle SHALL use the pre-swap bank_sel.
REQ-032 Both counters SHALL saturate at 255 and never wrap.

Reset
REQ-033 On reset low, SHALL asynchronously set bank_sel=0, state FILLING, frame_ready=0, rd_valid=0, rd_data=0, both counters=0 and the underrun flag=0; bank contents are unspecified.
REQ-034 Reset mid-frame SHALL abandon the partial frame; after release, the first wr_done is the first valid frame.

Structure
REQ-035 SHALL place the state encoding and the default DATA_W/ADDR_W constants in the shared project package.
REQ-036 SHALL instantiate one sub-module dual_port_bank (single write port, single registered read port) twice.

Verification
REQ-037 Scenario: fill 1024 words of value addr+1, pulse wr_done, pulse swap_req, read addr 5 -> bank_sel=1, rd_data=6 one cycle later, frame_ready=0.
REQ-038 Scenario: three swap_req with no wr_done, UNDERRUN_MODE=0 -> bank_sel unchanged, underrun_cnt=3, reads return the previous frame.
REQ-039 Scenario: same with UNDERRUN_MODE=1, FILL_WORD=0xABC -> every read returns 0xABC until the next good swap, after which stored data returns.
REQ-040 Scenario: wr_done, then 10 writes and 1 wr_done before swap_req -> overrun_cnt=11, the ready frame is intact after swap.
REQ-041 Scenario: wr_done and swap_req in the same cycle -> swap occurs, underrun_cnt unchanged, frame_ready=0.
REQ-042 Scenario: reset asserted mid-fill with counters at 255 -> all outputs at reset values immediately; no counter wraps before reset.
